// File: rtl/edge_event_pkg.sv
// Shared helpers for the edge event capture block: filter counter sizing and
// parameter legality.
package edge_event_pkg;

  // One bit of headroom over clog2 keeps FILTER_CYCLES=1 at a legal 1-bit width.
  function automatic int cnt_width(input int filter_cycles);
    return $clog2(filter_cycles) + 1;
  endfunction

  function automatic bit params_legal(input int channels, input int sync_stages,
                                      input int filter_cycles);
    return (channels >= 1) && (channels <= 32) && (sync_stages >= 2) &&
           (filter_cycles >= 1);
  endfunction

endpackage

// File: rtl/edge_event_channel.sv
// One capture channel: synchroniser, glitch filter, registered edge pulses and
// sticky pending/overrun flags.
module edge_event_channel
  import edge_event_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_signal_in,
  input  logic i_rise_en,
  input  logic i_fall_en,
  input  logic i_clear,
  output logic o_level,
  output logic o_positive_edge,
  output logic o_negative_edge,
  output logic o_pending,
  output logic o_overrun
);

  localparam int              CNT_W    = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync_p0;
  logic                   w_sync_p0;
  logic [CNT_W-1:0]       r_cnt_p1;
  logic                   r_level_p1;
  logic                   r_pos_p1;
  logic                   r_neg_p1;
  logic                   w_accept_p1;
  logic                   w_event_p2;
  logic                   r_pending_p2;
  logic                   r_overrun_p2;

  // Stage p0: metastability chain
  always_ff @(posedge i_clk) begin
    if (i_reset) r_sync_p0 <= '0;
    else         r_sync_p0 <= {r_sync_p0[SYNC_STAGES-2:0], i_signal_in};
  end

  assign w_sync_p0   = r_sync_p0[SYNC_STAGES-1];
  assign w_accept_p1 = (w_sync_p0 != r_level_p1) && (r_cnt_p1 == CNT_LAST);

  // Stage p1: stability filter; pulses register alongside the level update
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt_p1   <= '0;
      r_level_p1 <= 1'b0;
      r_pos_p1   <= 1'b0;
      r_neg_p1   <= 1'b0;
    end else begin
      r_pos_p1 <= w_accept_p1 & w_sync_p0;
      r_neg_p1 <= w_accept_p1 & ~w_sync_p0;
      if (w_sync_p0 == r_level_p1) begin
        r_cnt_p1 <= '0;
      end else if (w_accept_p1) begin
        r_level_p1 <= w_sync_p0;
        r_cnt_p1   <= '0;
      end else begin
        r_cnt_p1 <= r_cnt_p1 + CNT_W'(1);
      end
    end
  end

  assign w_event_p2 = (r_pos_p1 & i_rise_en) | (r_neg_p1 & i_fall_en);

  // Stage p2: sticky flags; a new event beats a simultaneous clear
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending_p2 <= 1'b0;
      r_overrun_p2 <= 1'b0;
    end else begin
      if (w_event_p2)   r_pending_p2 <= 1'b1;
      else if (i_clear) r_pending_p2 <= 1'b0;

      if (w_event_p2 && r_pending_p2 && !i_clear) r_overrun_p2 <= 1'b1;
      else if (i_clear && !w_event_p2)            r_overrun_p2 <= 1'b0;
    end
  end

  assign o_level         = r_level_p1;
  assign o_positive_edge = r_pos_p1;
  assign o_negative_edge = r_neg_p1;
  assign o_pending       = r_pending_p2;
  assign o_overrun       = r_overrun_p2;

endmodule

// File: rtl/edge_event_capture.sv
// Multi-channel edge event capture: independent channels plus an interrupt
// reduction over the pending flags.
module edge_event_capture
  import edge_event_pkg::*;
#(
  parameter int CHANNELS      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [CHANNELS-1:0] i_signal_in,
  input  logic [CHANNELS-1:0] i_rise_en,
  input  logic [CHANNELS-1:0] i_fall_en,
  input  logic [CHANNELS-1:0] i_clear,
  output logic [CHANNELS-1:0] o_level,
  output logic [CHANNELS-1:0] o_positive_edge,
  output logic [CHANNELS-1:0] o_negative_edge,
  output logic [CHANNELS-1:0] o_pending,
  output logic [CHANNELS-1:0] o_overrun,
  output logic                o_irq
);

  logic [CHANNELS-1:0] w_pending;

  if (!params_legal(CHANNELS, SYNC_STAGES, FILTER_CYCLES)) begin : g_bad_params
    $error("edge_event_capture: illegal CHANNELS/SYNC_STAGES/FILTER_CYCLES");
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    edge_event_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_ch (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_signal_in    (i_signal_in[g]),
      .i_rise_en      (i_rise_en[g]),
      .i_fall_en      (i_fall_en[g]),
      .i_clear        (i_clear[g]),
      .o_level        (o_level[g]),
      .o_positive_edge(o_positive_edge[g]),
      .o_negative_edge(o_negative_edge[g]),
      .o_pending      (w_pending[g]),
      .o_overrun      (o_overrun[g])
    );
  end

  assign o_pending = w_pending;
  assign o_irq     = |w_pending;

endmodule

// File: tb/tb_edge_event_capture.sv
// Directed bench for edge_event_capture with default parameters (8 ch, 2 sync, filter 4).
module tb_edge_event_capture;

  localparam int CH = 8;

  logic          clk;
  logic          reset;
  logic [CH-1:0] sig;
  logic [CH-1:0] rise_en;
  logic [CH-1:0] fall_en;
  logic [CH-1:0] clr;
  logic [CH-1:0] level;
  logic [CH-1:0] pos;
  logic [CH-1:0] neg;
  logic [CH-1:0] pending;
  logic [CH-1:0] overrun;
  logic          irq;

  int n_total = 0;
  int n_pass  = 0;
  int pos_cnt [CH];
  int neg_cnt [CH];
  int both_cnt = 0;

  edge_event_capture #(
    .CHANNELS     (CH),
    .SYNC_STAGES  (2),
    .FILTER_CYCLES(4)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_signal_in    (sig),
    .i_rise_en      (rise_en),
    .i_fall_en      (fall_en),
    .i_clear        (clr),
    .o_level        (level),
    .o_positive_edge(pos),
    .o_negative_edge(neg),
    .o_pending      (pending),
    .o_overrun      (overrun),
    .o_irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) begin
      pos_cnt[i] += int'(pos[i]);
      neg_cnt[i] += int'(neg[i]);
    end
    if ((pos & neg) != '0) both_cnt++;
  endtask

  task automatic zero_counts();
    for (int i = 0; i < CH; i++) begin
      pos_cnt[i] = 0;
      neg_cnt[i] = 0;
    end
  endtask

  initial begin
    reset = 1'b1; sig = '0; rise_en = '0; fall_en = '0; clr = '0;
    zero_counts();
    repeat (3) step();
    check("rst_level",   32'(level),   32'h0);
    check("rst_pos",     32'(pos),     32'h0);
    check("rst_neg",     32'(neg),     32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_irq",     32'(irq),     32'h0);
    reset = 1'b0;

    // ch0 clean rise
    rise_en = 8'h01;
    sig[0] = 1'b1;
    repeat (5) step();
    check("ch0_level_early", 32'(level[0]), 32'h0);
    step();
    check("ch0_level",       32'(level[0]),   32'h1);
    check("ch0_pos",         32'(pos[0]),     32'h1);
    check("ch0_pend_early",  32'(pending[0]), 32'h0);
    step();
    check("ch0_pos_end",     32'(pos[0]),     32'h0);
    check("ch0_pending",     32'(pending[0]), 32'h1);
    check("ch0_irq",         32'(irq),        32'h1);
    clr = 8'h01; step(); clr = '0;
    check("ch0_cleared",     32'(pending[0]), 32'h0);
    check("ch0_irq_low",     32'(irq),        32'h0);

    // ch1 glitch rejection, then a pulse exactly long enough
    rise_en = 8'h02; fall_en = 8'h02;
    zero_counts();
    sig[1] = 1'b1; repeat (3) step(); sig[1] = 1'b0;
    repeat (10) step();
    check("ch1_glitch_pos",   32'(pos_cnt[1]), 32'd0);
    check("ch1_glitch_neg",   32'(neg_cnt[1]), 32'd0);
    check("ch1_glitch_level", 32'(level[1]),   32'h0);
    check("ch1_glitch_pend",  32'(pending[1]), 32'h0);
    sig[1] = 1'b1; repeat (4) step(); sig[1] = 1'b0;
    repeat (2) step();
    check("ch1_pulse_pos",    32'(pos[1]),   32'h1);
    check("ch1_pulse_level",  32'(level[1]), 32'h1);
    repeat (3) step();
    check("ch1_neg_early",    32'(neg[1]),   32'h0);
    step();
    check("ch1_neg",          32'(neg[1]),   32'h1);
    check("ch1_level_low",    32'(level[1]), 32'h0);
    clr = 8'h02; step(); clr = '0;

    // ch2 falling-only events with overrun
    rise_en = '0; fall_en = 8'h04;
    sig[2] = 1'b1; repeat (8) step();
    check("ch2_rise_ignored", 32'(pending[2]), 32'h0);
    check("ch2_level_hi",     32'(level[2]),   32'h1);
    sig[2] = 1'b0; repeat (8) step();
    check("ch2_pend1",        32'(pending[2]), 32'h1);
    check("ch2_ovr1",         32'(overrun[2]), 32'h0);
    sig[2] = 1'b1; repeat (8) step();
    sig[2] = 1'b0; repeat (8) step();
    check("ch2_pend2",        32'(pending[2]), 32'h1);
    check("ch2_ovr2",         32'(overrun[2]), 32'h1);
    clr = 8'h04; step(); clr = '0;
    check("ch2_clr_pend",     32'(pending[2]), 32'h0);
    check("ch2_clr_ovr",      32'(overrun[2]), 32'h0);

    // ch3 event coincident with clear while already pending
    rise_en = 8'h08; fall_en = 8'h08;
    sig[3] = 1'b1; repeat (7) step();
    check("ch3_pend_first",   32'(pending[3]), 32'h1);
    sig[3] = 1'b0; repeat (6) step();
    check("ch3_neg_now",      32'(neg[3]),     32'h1);
    clr = 8'h08; step(); clr = '0;
    check("ch3_set_wins",     32'(pending[3]), 32'h1);
    check("ch3_no_overrun",   32'(overrun[3]), 32'h0);
    clr = 8'h08; step(); clr = '0;

    // ch4 reset in flight, input still high afterwards
    rise_en = 8'h10; fall_en = '0;
    zero_counts();
    sig[4] = 1'b1; repeat (2) step();
    reset = 1'b1; repeat (2) step();
    check("ch4_rst_level",    32'(level),      32'h0);
    check("ch4_rst_pos",      32'(pos_cnt[4]), 32'd0);
    check("ch4_rst_pending",  32'(pending),    32'h0);
    reset = 1'b0;
    repeat (5) step();
    check("ch4_pos_early",    32'(pos[4]),     32'h0);
    step();
    check("ch4_pos",          32'(pos[4]),     32'h1);
    check("ch4_level",        32'(level[4]),   32'h1);
    repeat (4) step();
    check("ch4_pos_once",     32'(pos_cnt[4]), 32'd1);

    // all channels at once
    sig = '0; rise_en = 8'hFF; fall_en = 8'hFF;
    repeat (8) step();
    clr = 8'hFF; step(); clr = '0;
    check("all_pend_clear",   32'(pending), 32'h0);
    check("all_irq_low",      32'(irq),     32'h0);
    sig = 8'hFF;
    repeat (5) step();
    check("all_pos_early",    32'(pos),     32'h0);
    step();
    check("all_pos",          32'(pos),     32'hFF);
    check("all_level",        32'(level),   32'hFF);
    step();
    check("all_pending",      32'(pending), 32'hFF);
    check("all_irq",          32'(irq),     32'h1);
    check("all_ovr_none",     32'(overrun), 32'h0);
    sig = '0;
    repeat (6) step();
    check("all_neg",          32'(neg),     32'hFF);
    check("all_neg_only",     32'(pos),     32'h0);
    step();
    check("all_overrun",      32'(overrun), 32'hFF);
    check("never_both",       32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
